down_timer_multi: RTL and testbench
===================================

Name: down_timer_multi

Overview:
Parametrised multi-channel down-counting timer. It is the next generation of the single 16-bit down_counter. Each channel has its own reload register, mode, start/stop control and sticky interrupt status. A shared prescaler sets the count rate. The summed interrupt goes to the system interrupt controller.

Parameters:
WIDTH, 16, counter and reload width per channel
NCH, 4, number of independent channels (1..16)
PSC_W, 8, prescaler width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  configuration write strobe
cfg_ch  in  $clog2(NCH) (min 1)  channel selected by cfg_we
cfg_mode  in  2  mode to write: 00 free-running, 01 cyclic, 10 single, 11 reserved
cfg_reload  in  WIDTH  reload value to write
prescale  in  PSC_W  tick divider; tick every prescale+1 clk cycles
start  in  NCH  per-channel start pulse
stop  in  NCH  per-channel stop pulse
irq_en  in  NCH  per-channel interrupt enable
irq_clr  in  NCH  per-channel status clear pulse
count  out  NCH*WIDTH  live counts; channel i is at [i*WIDTH +: WIDTH]
running  out  NCH  channel is in RUN
irq_stat  out  NCH  sticky expiry flags
irq  out  1  OR over (irq_stat & irq_en)

Behaviour:
- Reset (asynchronous, immediate): count, running, irq_stat and irq go to 0. The mode and reload registers and the prescaler counter also go to 0.
- Prescaler:
  - A shared counter runs from 0 to prescale, then returns to 0. tick=1 in the cycle where the counter equals prescale.
  - prescale=0 gives tick every cycle.
  - The prescaler runs freely and is not synchronised to start.
  - A change to prescale takes effect at the next wrap. If the counter is already above the new value, it runs on to its maximum and wraps.
- Config write: on a cfg_we edge, mode[cfg_ch] and reload[cfg_ch] are registered.
  - A mode change takes effect on the next tick.
  - A reload change on a running channel takes effect at the next reload.
- Per-channel FSM, states IDLE and RUN:
  - IDLE, start=1: next edge count <= reload, state RUN. This ignores tick.
  - If cfg_we targets this channel in the same cycle as start, the new cfg_reload is loaded (bypass).
  - RUN, tick=1, count!=0: count <= count-1.
  - RUN, tick=1, count==0 (expiry): irq_stat set on the same edge, then by mode:
    - free-running: count <= all-ones (2^WIDTH-1) and stays in RUN.
    - cyclic: count <= reload and stays in RUN.
    - single: count holds 0 and state goes to IDLE.
    - reserved: count holds 0, state goes to IDLE and irq_stat is NOT set.
  - A cyclic channel therefore has a period of (reload+1) ticks. reload=0 in cyclic mode expires on every tick.
  - RUN, start=1 (without stop): restart, count <= reload, state stays RUN.
  - stop=1 in any state: state IDLE, count holds. stop wins over start and over expiry in the same cycle (no irq set).
- Interrupt:
  - irq_stat[i] is cleared by irq_clr[i]. Set wins if expiry and clear happen in the same cycle.
  - irq is registered from irq_stat & irq_en, so it lags irq_stat by one cycle.
  - irq_en does not affect irq_stat.
- Latency:
  - start to count=reload: 1 edge.
  - Expiry to irq_stat: same edge.
  - Expiry to irq: 1 further edge.

Decomposition:
- down_timer_pkg holds:
  - mode constants MODE_FREE=2'b00, MODE_CYCLIC=2'b01, MODE_SINGLE=2'b10, MODE_RSVD=2'b11;
  - the state enum ST_IDLE/ST_RUN.
- Sub-module down_timer_chan: one channel holding the FSM, count, mode/reload registers and irq_stat. It takes tick as an input.
- The top level contains the prescaler, the cfg_ch decode, a generate loop of NCH channels and the irq reduction.

Test Plan:
1. prescale=0; cfg ch0 cyclic, reload=3; pulse start[0] -> count0 sequence 3,2,1,0,3,2... irq_stat[0] rises on each 0->3 edge, every 4 cycles; irq follows 1 cycle later with irq_en[0]=1.
2. ch1 single, reload=2; start -> count1 2,1,0, then holds 0; running[1] falls on the expiry edge; irq_stat[1] set once; irq_clr[1] clears it; no further sets.
3. ch2 free-running, reload=1 -> count2 1,0,FFFF,FFFE...; irq_stat[2] set at the 0->FFFF edge.
4. prescale=3; ch0 cyclic, reload=2 -> count0 changes only every 4th cycle (2,2,2,2,1,...); expiry every 12 cycles.
5. Collisions:
   - irq_clr[0] in the same cycle as expiry -> irq_stat[0] stays 1.
   - start[3]+stop[3] together -> running[3]=0.
   - cfg_we (ch3, reload=7) + start[3] -> count3=7.
   - reload written mid-run on cyclic ch0 -> old value is used until the next expiry.
6. Assert reset mid-count (count0=0x0005, not on a clk edge) -> all outputs read 0 immediately; after release the channel stays IDLE until start.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared definitions for the multi-channel down timer: channel modes and FSM states.
package down_timer_pkg;

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_CYCLIC = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_timer_chan.sv
// One timer channel: mode/reload registers, IDLE/RUN FSM, down counter and sticky expiry flag.
module down_timer_chan
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             cfg_sel,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_reload,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             irq_stat
);

  state_t           state, state_d;
  logic [1:0]       mode;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] count_d;
  logic             expire_set;

  // stop dominates start and expiry; start ignores tick; a same-cycle config write bypasses reload
  always_comb begin
    state_d    = state;
    count_d    = count;
    expire_set = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      count_d = cfg_sel ? cfg_reload : reload;
      state_d = ST_RUN;
    end else if (state == ST_RUN && tick) begin
      if (count != '0) begin
        count_d = count - WIDTH'(1);
      end else begin
        case (mode)
          MODE_FREE: begin
            count_d    = '1;
            expire_set = 1'b1;
          end
          MODE_CYCLIC: begin
            count_d    = reload;
            expire_set = 1'b1;
          end
          MODE_SINGLE: begin
            state_d    = ST_IDLE;
            expire_set = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      mode     <= MODE_FREE;
      reload   <= '0;
      irq_stat <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      irq_stat <= expire_set | (irq_stat & ~irq_clr);
      if (cfg_sel) begin
        mode   <= cfg_mode;
        reload <= cfg_reload;
      end
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: rtl/down_timer_multi.sv
// Multi-channel down timer: shared free-running prescaler, per-channel timers, summed interrupt.
module down_timer_multi
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int PSC_W = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                             cfg_mode,
  input  logic [WIDTH-1:0]                       cfg_reload,
  input  logic [PSC_W-1:0]                       prescale,
  input  logic [NCH-1:0]                         start,
  input  logic [NCH-1:0]                         stop,
  input  logic [NCH-1:0]                         irq_en,
  input  logic [NCH-1:0]                         irq_clr,
  output logic [NCH*WIDTH-1:0]                   count,
  output logic [NCH-1:0]                         running,
  output logic [NCH-1:0]                         irq_stat,
  output logic                                   irq
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PSC_W-1:0] psc_cnt;
  logic             tick;
  logic [NCH-1:0]   cfg_sel;

  // Live compare against prescale; a counter left above a lowered value overflows back to 0
  assign tick = (psc_cnt == prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign cfg_sel[i] = cfg_we && (cfg_ch == CH_W'(i));

    down_timer_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .cfg_sel    (cfg_sel[i]),
      .cfg_mode   (cfg_mode),
      .cfg_reload (cfg_reload),
      .start      (start[i]),
      .stop       (stop[i]),
      .irq_clr    (irq_clr[i]),
      .count      (count[i*WIDTH +: WIDTH]),
      .running    (running[i]),
      .irq_stat   (irq_stat[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(irq_stat & irq_en);
    end
  end

endmodule

// File: tb/tb_down_timer_multi.sv
// Self-checking bench for down_timer_multi: directed scenarios plus random stimulus vs. a behavioural model.
module tb_down_timer_multi;

  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int PSC_W = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_we;
  logic [1:0]           cfg_ch;
  logic [1:0]           cfg_mode;
  logic [WIDTH-1:0]     cfg_reload;
  logic [PSC_W-1:0]     prescale;
  logic [NCH-1:0]       start, stop, irq_en, irq_clr;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       running, irq_stat;
  logic                 irq;

  down_timer_multi #(
    .WIDTH(WIDTH),
    .NCH  (NCH),
    .PSC_W(PSC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_reload(cfg_reload),
    .prescale  (prescale),
    .start     (start),
    .stop      (stop),
    .irq_en    (irq_en),
    .irq_clr   (irq_clr),
    .count     (count),
    .running   (running),
    .irq_stat  (irq_stat),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int mcnt[NCH];
  bit mrun[NCH];
  bit mstat[NCH];
  int mmode[NCH];
  int mrel[NCH];
  int mpsc;
  bit mirq;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mcnt[i] = 0; mrun[i] = 0; mstat[i] = 0; mmode[i] = 0; mrel[i] = 0;
    end
    mpsc = 0;
    mirq = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge state and current inputs
  task automatic model_step();
    bit tick;
    bit nirq;
    bit sel;
    bit setf;
    tick = (mpsc == int'(prescale));
    nirq = 0;
    for (int i = 0; i < NCH; i++) nirq |= mstat[i] & irq_en[i];
    mpsc = tick ? 0 : (mpsc + 1) % (1 << PSC_W);
    for (int i = 0; i < NCH; i++) begin
      sel  = cfg_we && (int'(cfg_ch) == i);
      setf = 0;
      if (stop[i]) begin
        mrun[i] = 0;
      end else if (start[i]) begin
        mcnt[i] = sel ? int'(cfg_reload) : mrel[i];
        mrun[i] = 1;
      end else if (mrun[i] && tick) begin
        if (mcnt[i] > 0) mcnt[i] = mcnt[i] - 1;
        else begin
          case (mmode[i])
            0: begin mcnt[i] = MAXV; setf = 1; end
            1: begin mcnt[i] = mrel[i]; setf = 1; end
            2: begin mrun[i] = 0; setf = 1; end
            default: mrun[i] = 0;
          endcase
        end
      end
      mstat[i] = setf | (mstat[i] & !irq_clr[i]);
      if (sel) begin
        mmode[i] = int'(cfg_mode);
        mrel[i]  = int'(cfg_reload);
      end
    end
    mirq = nirq;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCH; i++) begin
      check_eq($sformatf("count%0d", i), 64'(count[i*WIDTH +: WIDTH]), 64'(mcnt[i]));
      check_eq($sformatf("running%0d", i), 64'(running[i]), 64'(mrun[i]));
      check_eq($sformatf("irq_stat%0d", i), 64'(irq_stat[i]), 64'(mstat[i]));
    end
    check_eq("irq", 64'(irq), 64'(mirq));
  endtask

  task automatic clear_pulses();
    cfg_we = 0; start = '0; stop = '0; irq_clr = '0;
  endtask

  // Apply current inputs across one edge, check, then drop the pulse inputs
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    clear_pulses();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic cfg(input int ch, input int mode, input int rel);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_reload = WIDTH'(rel);
  endtask

  initial begin
    reset = 1; cfg_we = 0; cfg_ch = '0; cfg_mode = '0; cfg_reload = '0;
    prescale = '0; start = '0; stop = '0; irq_en = '0; irq_clr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 0;

    // cyclic ch0 reload 3, prescale 0
    irq_en = '1;
    cfg(0, 1, 3); cycle();
    start[0] = 1; cycle();
    check_eq("c0_first", 64'(count[0 +: WIDTH]), 64'd3);
    run(12);

    // single ch1 reload 2, then clear
    cfg(1, 2, 2); cycle();
    start[1] = 1; cycle();
    run(5);
    check_eq("c1_idle", 64'(running[1]), 64'd0);
    irq_clr[1] = 1; cycle();
    check_eq("c1_clr", 64'(irq_stat[1]), 64'd0);
    run(4);

    // free-running ch2 reload 1
    cfg(2, 0, 1); cycle();
    start[2] = 1; cycle();
    run(3);
    check_eq("c2_wrap", 64'(count[2*WIDTH +: WIDTH]), 64'(MAXV - 1));

    // prescale 3, cyclic ch0 reload 2
    prescale = 8'd3;
    cfg(0, 1, 2); cycle();
    start[0] = 1; cycle();
    run(30);

    // clear colliding with expiry on ch0
    begin
      int k;
      k = 0;
      while (!(mrun[0] && mcnt[0] == 0 && mpsc == int'(prescale)) && k < 50) begin
        cycle(); k++;
      end
      check_eq("tmo_expiry", 64'(k < 50), 64'd1);
    end
    irq_clr[0] = 1; cycle();
    check_eq("clr_vs_set", 64'(irq_stat[0]), 64'd1);

    // start+stop together, then config bypass on start
    start[3] = 1; stop[3] = 1; cycle();
    check_eq("startstop", 64'(running[3]), 64'd0);
    cfg(3, 1, 7); start[3] = 1; cycle();
    check_eq("bypass", 64'(count[3*WIDTH +: WIDTH]), 64'd7);

    // mid-run reload change on ch0
    cfg(0, 1, 5); cycle();
    run(40);

    // asynchronous reset mid-count
    begin
      int k;
      k = 0;
      while (mcnt[0] != 5 && k < 100) begin
        cycle(); k++;
      end
      check_eq("tmo_cnt5", 64'(k < 100), 64'd1);
    end
    #2;
    reset = 1;
    #1;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_running", 64'(running), 64'd0);
    check_eq("rst_stat", 64'(irq_stat), 64'd0);
    check_eq("rst_irq", 64'(irq), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    run(6);

    // randomized phase
    prescale = 8'(($urandom_range(0, 3)));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        cfg_we = 1; cfg_ch = 2'($urandom_range(0, 3));
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_reload = WIDTH'($urandom_range(0, 9));
      end
      for (int i = 0; i < NCH; i++) begin
        start[i]   = ($urandom_range(0, 19) == 0);
        stop[i]    = ($urandom_range(0, 39) == 0);
        irq_clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 15) == 0) irq_en = NCH'($urandom);
      if ($urandom_range(0, 199) == 0) prescale = 8'($urandom_range(0, 3));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
